// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion scheduler: channel codes, FSM
// state encoding, default timing constants and channel-pick helpers.
package adc_pkg;

  localparam logic [1:0] CH_SIG  = 2'd0;
  localparam logic [1:0] CH_ZERO = 2'd1;
  localparam logic [1:0] CH_REF  = 2'd2;

  localparam int START_GAP_DEF   = 160;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_GAP    = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_EMIT   = 3'd6
  } state_t;

  // Returns {found, channel} for the lowest enabled channel at or above ptr.
  function automatic logic [2:0] pick_ch(input logic [2:0] mask, input logic [1:0] ptr);
    pick_ch = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= ptr)) begin
        pick_ch = {1'b1, 2'(i)};
      end
    end
  endfunction

  function automatic logic is_last(input logic [2:0] mask, input logic [1:0] ch);
    case (ch)
      CH_SIG:  is_last = !(mask[1] || mask[2]);
      CH_ZERO: is_last = !mask[2];
      CH_REF:  is_last = 1'b1;
      default: is_last = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/adc_seq_acc.sv
// Sign-extending sample accumulator; avg_next is the average that the
// accumulator would hold after adding din, so the final word needs no extra cycle.
module adc_seq_acc
  import adc_pkg::*;
#(
  parameter int RES_W = 32
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic [RES_W-1:0] din,
  input  logic [2:0]       shift,
  output logic [RES_W-1:0] avg_next
);

  localparam int ACC_W = RES_W + 8;

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] sum_s;

  assign sum_s    = acc_r + {{8{din[RES_W-1]}}, din};
  assign avg_next = RES_W'(sum_s >>> shift);

  // Accumulator register: clear wins over add.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (add) begin
      acc_r <= sum_s;
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Multislope ADC conversion scheduler: scans enabled channels, averages 2^n
// results each and emits channel-tagged words. ADC_SEQ_TIMEOUT_EN adds the WAIT timeout.
module adc_seq_ctrl
  import adc_pkg::*;
#(
  parameter int RES_W       = 32,
  parameter int SETTLE_W    = 16,
  parameter int START_GAP   = START_GAP_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic                run,
  input  logic [2:0]          cfg_mask,
  input  logic [2:0]          cfg_navg_log2,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [1:0]          mux_sel,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [RES_W-1:0]    conv_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W+1:0]    out_data,
  output logic                busy,
  output logic                err_timeout
);

  localparam int GAP_W = $clog2(START_GAP + 1);

  state_t              state_r;
  logic [2:0]          mask_r;
  logic [2:0]          navg_r;
  logic [SETTLE_W-1:0] settle_r;
  logic [SETTLE_W-1:0] settle_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [1:0]          ptr_r;
  logic [7:0]          cnt_r;
  logic                skip_r;
  logic [2:0]          pick_s;
  logic                last_s;
  logic                final_s;
  logic                acc_clr_s;
  logic                acc_add_s;
  logic [RES_W-1:0]    avg_next_s;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] wait_cnt_r;
  logic             err_timeout_r;
  assign err_timeout = err_timeout_r;
`else
  assign err_timeout = 1'b0;
`endif

  assign pick_s    = pick_ch(mask_r, ptr_r);
  assign last_s    = is_last(mask_r, mux_sel);
  assign final_s   = (cnt_r == ((8'd1 << navg_r) - 8'd1));
  assign acc_clr_s = (state_r == S_SELECT);
  assign acc_add_s = (state_r == S_WAIT) && run && conv_done;

  adc_seq_acc #(.RES_W(RES_W)) u_acc (
    .mclk     (mclk),
    .rst      (rst),
    .clr      (acc_clr_s),
    .add      (acc_add_s),
    .din      (conv_result),
    .shift    (navg_r),
    .avg_next (avg_next_s)
  );

  // Scan FSM with all outputs registered; run low aborts any conversion phase.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      mask_r       <= 3'd0;
      navg_r       <= 3'd0;
      settle_r     <= {SETTLE_W{1'b0}};
      settle_cnt_r <= {SETTLE_W{1'b0}};
      gap_cnt_r    <= {GAP_W{1'b0}};
      ptr_r        <= 2'd0;
      cnt_r        <= 8'd0;
      skip_r       <= 1'b0;
      mux_sel      <= 2'd0;
      conv_start   <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= {(RES_W+2){1'b0}};
      busy         <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      wait_cnt_r    <= {TMO_W{1'b0}};
      err_timeout_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          mask_r   <= cfg_mask;
          navg_r   <= cfg_navg_log2;
          settle_r <= cfg_settle;
          ptr_r    <= 2'd0;
          skip_r   <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
          if (!run) err_timeout_r <= 1'b0;
`endif
          if (run && (cfg_mask != 3'd0)) begin
            state_r <= S_SELECT;
            busy    <= 1'b1;
          end
        end
        S_SELECT: begin
          if (run && pick_s[2]) begin
            mux_sel      <= pick_s[1:0];
            cnt_r        <= 8'd0;
            settle_cnt_r <= {SETTLE_W{1'b0}};
            state_r      <= S_SETTLE;
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (!run) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else if (settle_cnt_r == settle_r) begin
            gap_cnt_r <= {GAP_W{1'b0}};
            state_r   <= S_GAP;
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
          end
        end
        S_GAP: begin
          if (!run) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else if (gap_cnt_r == GAP_W'(START_GAP - 1)) begin
            skip_r  <= 1'b0;
            state_r <= skip_r ? S_SELECT : S_START;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        S_START: begin
          if (!run) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            conv_start <= 1'b1;
            state_r    <= S_WAIT;
`ifdef ADC_SEQ_TIMEOUT_EN
            wait_cnt_r <= {TMO_W{1'b0}};
`endif
          end
        end
        S_WAIT: begin
          if (!run) begin
            conv_start <= 1'b0;
            state_r    <= S_IDLE;
            busy       <= 1'b0;
          end else if (conv_done) begin
            conv_start <= 1'b0;
            if (final_s) begin
              out_data  <= {mux_sel, avg_next_s};
              out_valid <= 1'b1;
              state_r   <= S_EMIT;
            end else begin
              cnt_r     <= cnt_r + 8'd1;
              gap_cnt_r <= {GAP_W{1'b0}};
              state_r   <= S_GAP;
            end
          end else begin
`ifdef ADC_SEQ_TIMEOUT_EN
            // Expired channel is dropped; the GAP still runs before the next SELECT.
            if (wait_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
              err_timeout_r <= 1'b1;
              conv_start    <= 1'b0;
              gap_cnt_r     <= {GAP_W{1'b0}};
              skip_r        <= 1'b1;
              state_r       <= S_GAP;
              if (last_s) begin
                ptr_r    <= 2'd0;
                mask_r   <= cfg_mask;
                navg_r   <= cfg_navg_log2;
                settle_r <= cfg_settle;
              end else begin
                ptr_r <= mux_sel + 2'd1;
              end
            end else begin
              wait_cnt_r <= wait_cnt_r + TMO_W'(1);
            end
`endif
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_s) begin
              ptr_r    <= 2'd0;
              mask_r   <= cfg_mask;
              navg_r   <= cfg_navg_log2;
              settle_r <= cfg_settle;
            end else begin
              ptr_r <= mux_sel + 2'd1;
            end
            if (run) begin
              state_r <= S_SELECT;
            end else begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          conv_start <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: a converter model answers conv_start,
// expected words are queued by the stimulus and checked by a separate monitor.
module tb_adc_seq_ctrl;

  localparam int RES_W = 32;
  localparam int SW    = 16;
  localparam int GAP   = 16;
  localparam int TMO   = 1000;

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [2:0]    cfg_mask = 3'd0;
  logic [2:0]    cfg_navg_log2 = 3'd0;
  logic [SW-1:0] cfg_settle = 16'd0;
  logic          conv_done_r = 1'b0;
  logic          spur_done = 1'b0;
  logic [31:0]   conv_result = 32'd0;
  logic          out_ready = 1'b1;
  logic [1:0]    mux_sel;
  logic          conv_start;
  logic          out_valid;
  logic [33:0]   out_data;
  logic          busy;
  logic          err_timeout;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          res_q[$];
  logic [33:0] exp_q[$];
  int          rise_q[$];
  int          done_q[$];
  int          vrise_q[$];
  logic [1:0]  rmux_q[$];

  adc_seq_ctrl #(
    .RES_W(RES_W), .SETTLE_W(SW), .START_GAP(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .mclk          (mclk),
    .rst           (rst),
    .run           (run),
    .cfg_mask      (cfg_mask),
    .cfg_navg_log2 (cfg_navg_log2),
    .cfg_settle    (cfg_settle),
    .mux_sel       (mux_sel),
    .conv_start    (conv_start),
    .conv_done     (conv_done_r | spur_done),
    .conv_result   (conv_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Converter model: answers each conv_start rise with the next queued result.
  initial begin : responder
    logic cs_prev;
    bit   pend;
    int   dly;
    cs_prev = 1'b0;
    pend = 1'b0;
    dly = 0;
    forever begin
      @(negedge mclk);
      conv_done_r = 1'b0;
      if (rst) begin
        cs_prev = 1'b0;
        pend = 1'b0;
      end else begin
        if (conv_start && !cs_prev) begin
          rise_q.push_back(cyc);
          rmux_q.push_back(mux_sel);
          if (res_q.size() > 0) begin
            pend = 1'b1;
            dly = 3;
          end
        end
        cs_prev = conv_start;
        if (pend) begin
          if (dly == 0) begin
            conv_done_r = 1'b1;
            conv_result = 32'(res_q.pop_front());
            done_q.push_back(cyc + 1);
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted output word.
  initial begin : monitor
    logic ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge mclk);
      if (!rst) begin
        if (out_valid && !ov_prev) vrise_q.push_back(cyc);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h expected no word", out_data);
          end else begin
            chk("word", 64'(out_data), 64'(exp_q.pop_front()));
          end
        end
      end
      ov_prev = out_valid & ~rst;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic clear_logs();
    res_q.delete(); exp_q.delete(); rise_q.delete();
    done_q.delete(); vrise_q.delete(); rmux_q.delete();
  endtask

  task automatic set_ready(input logic v);
    @(posedge mclk);
    #1 out_ready = v;
  endtask

  task automatic wait_drained(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge mclk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_rises(input string name, input int n, input int limit);
    for (int i = 0; i < limit && rise_q.size() < n; i++) @(negedge mclk);
    chk(name, 64'(rise_q.size() >= n), 64'd1);
  endtask

  task automatic stop_run(input string name);
    @(negedge mclk);
    run = 1'b0;
    cycles(3);
    chk(name, 64'(busy), 64'd0);
  endtask

  initial begin : stim
    int nr;
    int bad;
    int errc;
    cycles(3);
    chk("rst_mux_sel", 64'(mux_sel), 64'd0);
    chk("rst_conv_start", 64'(conv_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    @(negedge mclk);
    rst = 1'b0;
    cycles(2);

    // Single channel, four samples: (100+102+98+104)/4 = 101.
    clear_logs();
    cfg_mask = 3'b001; cfg_navg_log2 = 3'd2; cfg_settle = 16'd10;
    res_q = '{100, 102, 98, 104};
    exp_q.push_back({2'd0, 32'd101});
    run = 1'b1;
    wait_drained("t1_word_drained", 800);
    wait_rises("t1_next_scan", 5, 400);
    chk("t1_done_to_start", 64'(rise_q[1] - done_q[0]), 64'(GAP + 1));
    chk("t1_done_to_valid", 64'(vrise_q[0] - done_q[3]), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    stop_run("t1_idle");

    // Channels 0 and 2, single sample each; channel 1 skipped.
    clear_logs();
    cfg_mask = 3'b101; cfg_navg_log2 = 3'd0;
    res_q = '{-5, 7};
    exp_q.push_back({2'd0, 32'hFFFF_FFFB});
    exp_q.push_back({2'd2, 32'd7});
    run = 1'b1;
    wait_drained("t2_words_drained", 800);
    wait_rises("t2_wrap", 3, 400);
    chk("t2_mux0", 64'(rmux_q[0]), 64'd0);
    chk("t2_mux1", 64'(rmux_q[1]), 64'd2);
    chk("t2_mux2", 64'(rmux_q[2]), 64'd0);
    stop_run("t2_idle");

    // Back-pressure: word held for 50 cycles, then delivered after run falls.
    clear_logs();
    cfg_mask = 3'b001; cfg_navg_log2 = 3'd0;
    res_q = '{55};
    set_ready(1'b0);
    @(negedge mclk);
    run = 1'b1;
    for (int i = 0; i < 400 && !out_valid; i++) @(negedge mclk);
    chk("t3_valid", 64'(out_valid), 64'd1);
    nr = rise_q.size();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      if (out_valid !== 1'b1 || out_data !== {2'd0, 32'd55}) bad++;
    end
    chk("t3_hold_stable", 64'(bad), 64'd0);
    chk("t3_no_new_start", 64'(rise_q.size()), 64'(nr));
    @(negedge mclk);
    run = 1'b0;
    exp_q.push_back({2'd0, 32'd55});
    set_ready(1'b1);
    wait_drained("t3_word_drained", 50);
    cycles(3);
    chk("t3_idle_after_emit", 64'(busy), 64'd0);

    // Abort in WAIT after one of four samples, then a fresh average (10+20+30+40)/4.
    clear_logs();
    cfg_mask = 3'b001; cfg_navg_log2 = 3'd2; cfg_settle = 16'd2;
    res_q = '{7};
    run = 1'b1;
    wait_rises("t4_second_start", 2, 400);
    cycles(5);
    run = 1'b0;
    @(negedge mclk);
    chk("t4_abort_conv_start", 64'(conv_start), 64'd0);
    chk("t4_abort_busy", 64'(busy), 64'd0);
    cycles(20);
    chk("t4_no_word", 64'(vrise_q.size()), 64'd0);
    clear_logs();
    res_q = '{10, 20, 30, 40};
    exp_q.push_back({2'd0, 32'd25});
    run = 1'b1;
    wait_drained("t4_restart_word", 800);
    stop_run("t4_idle");

    // Asynchronous reset in GAP on channel 2, then spurious conv_done in IDLE.
    clear_logs();
    cfg_mask = 3'b100; cfg_navg_log2 = 3'd2; cfg_settle = 16'd10;
    run = 1'b1;
    cycles(20);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_mux_sel", 64'(mux_sel), 64'd0);
    chk("t5_rst_out_data", 64'(out_data), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_conv_start", 64'(conv_start), 64'd0);
    run = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    conv_result = 32'd999;
    spur_done = 1'b1;
    @(negedge mclk);
    spur_done = 1'b0;
    cycles(3);
    chk("t5_spurious_busy", 64'(busy), 64'd0);
    chk("t5_spurious_valid", 64'(out_valid), 64'd0);
    clear_logs();
    cfg_mask = 3'b001; cfg_navg_log2 = 3'd0;
    res_q = '{3};
    exp_q.push_back({2'd0, 32'd3});
    run = 1'b1;
    wait_drained("t5_word_after_reset", 800);
    stop_run("t5_idle");

    // Converter never answers.
    clear_logs();
    cfg_mask = 3'b001; cfg_navg_log2 = 3'd0;
    run = 1'b1;
    wait_rises("t6_start", 1, 400);
`ifdef ADC_SEQ_TIMEOUT_EN
    for (int i = 0; i < TMO + 50 && !err_timeout; i++) @(negedge mclk);
    errc = cyc;
    chk("t6_err_at_expiry", 64'(errc - rise_q[0]), 64'(TMO));
    wait_rises("t6_channel_skipped", 2, 400);
    chk("t6_no_word", 64'(vrise_q.size()), 64'd0);
    chk("t6_err_sticky", 64'(err_timeout), 64'd1);
    run = 1'b0;
    cycles(3);
    chk("t6_err_cleared", 64'(err_timeout), 64'd0);
`else
    errc = 0;
    cycles(TMO + 100);
    chk("t6_err_tied_low", 64'(err_timeout), 64'(errc));
    chk("t6_still_waiting", 64'(busy), 64'd1);
    chk("t6_single_start", 64'(rise_q.size()), 64'd1);
    stop_run("t6_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
